halftone_bitpacker: RTL and testbench

- Downstream stage of the halftone converter. Starts once error diffusion has finished (start tied to diff_done).
- Reads the IMG_W x IMG_H 8-bit halftoned frame from the shared image RAM in raster order and thresholds each pixel to 1 bit.
- Packs 8 pixels per byte and streams the bytes out on a valid/ready interface with row and frame markers, for the output DMA/UART.

---
 rtl/halftone_bitpacker.sv | 229 ++++++++++++++++++++++
 tb/tb_halftone_bitpacker.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/halftone_bitpacker.sv
`default_nettype none
// ============================================================================
// Module      : halftone_bitpacker
// Description : Reads the halftoned frame from the shared image RAM in raster
//               order, thresholds each pixel to one bit, packs 8 pixels per
//               byte (first pixel in bit 7) and streams the bytes on a
//               valid/ready interface with row and frame markers.
//               Optional macro PACK_ROW_CHECKSUM_EN appends an XOR checksum
//               byte after every row.
// Revision    : 1.0 - initial release
// ============================================================================
module halftone_bitpacker #(
    parameter int IMG_W  = 512,
    parameter int IMG_H  = 512,
    parameter int ADDR_W = 18,
    parameter int THRESH = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              ram_ren,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [7:0]        ram_odata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              out_last_row,
    output logic              out_last_frame,
    output logic              busy,
    output logic              done
);

    localparam int                c_COLS      = IMG_W / 8;
    localparam int                c_COL_W     = $clog2(c_COLS + 1);
    localparam int                c_ROW_W     = $clog2(IMG_H + 1);
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [c_COL_W-1:0] c_LAST_COL = c_COL_W'(c_COLS - 1);
    localparam logic [c_ROW_W-1:0] c_LAST_ROW = c_ROW_W'(IMG_H - 1);
    localparam logic [7:0]        c_THRESH    = 8'(THRESH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    logic [ADDR_W-1:0]    r_next_addr;   // next address to present
    logic                 r_dv;          // RAM data valid this cycle
    logic [6:0]           r_shift;       // bits collected so far in the group
    logic [2:0]           r_bcnt;        // position of the next bit in the group
    logic                 r_pend_valid;  // completed group waiting for the output register
    logic [7:0]           r_pend_byte;
    logic [c_COL_W-1:0]   r_col;         // byte index within the row of the next data byte
    logic [c_ROW_W-1:0]   r_row;         // row of the next data byte

    logic       w_start, w_bit, w_grp_done, w_out_free, w_accept, w_ck_pend;
    logic       w_ld_pend, w_ld_grp, w_ld_data, w_grp_to_pend, w_row_end;
    logic       w_pend_next, w_ck_next, w_stall, w_can_issue;
    logic [7:0] w_byte, w_data_byte;

    assign w_start     = (r_state == S_IDLE) && start;
    assign w_bit       = (ram_odata >= c_THRESH);
    assign w_byte      = {r_shift, w_bit};
    assign w_grp_done  = r_dv && (r_bcnt == 3'd7);
    assign w_out_free  = !out_valid || out_ready;
    assign w_accept    = out_valid && out_ready;
    assign w_stall     = out_valid && !out_ready;

    // Output register load priority: held-over group, then checksum, then the
    // group completing this cycle. Only one source can be live at a time.
    assign w_ld_pend     = w_out_free && r_pend_valid;
    assign w_ld_grp      = w_out_free && !r_pend_valid && !w_ck_pend && w_grp_done;
    assign w_grp_to_pend = w_grp_done && !w_ld_grp;
    assign w_ld_data     = w_ld_pend || w_ld_grp;
    assign w_data_byte   = r_pend_valid ? r_pend_byte : w_byte;
    assign w_row_end     = w_ld_data && (r_col == c_LAST_COL);
    assign w_pend_next   = (r_pend_valid && !w_ld_pend) || w_grp_to_pend;

`ifdef PACK_ROW_CHECKSUM_EN
    logic       r_ck_pend;
    logic [7:0] r_xor;
    logic       w_ld_ck;
    assign w_ck_pend = r_ck_pend;
    assign w_ld_ck   = w_out_free && !r_pend_valid && r_ck_pend;
    assign w_ck_next = (r_ck_pend && !w_ld_ck) || w_row_end;
`else
    assign w_ck_pend = 1'b0;
    assign w_ck_next = 1'b0;
`endif

    // Reads are only issued when a finished group is guaranteed somewhere to
    // go; at most one read is in flight when a stall begins, and it only
    // lands in the emptied shift register.
    assign w_can_issue = !w_pend_next && !w_ck_next && !w_stall;

    // Frame control FSM: sequences address issue, drain and the done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            ram_ren     <= 1'b0;
            ram_addr    <= '0;
            r_next_addr <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_FETCH;
                        busy        <= 1'b1;
                        ram_ren     <= 1'b1;
                        ram_addr    <= '0;
                        r_next_addr <= ADDR_W'(1);
                    end
                end
                S_FETCH: begin
                    if (ram_ren && (ram_addr == c_LAST_ADDR)) begin
                        ram_ren <= 1'b0;
                        r_state <= S_DRAIN;
                    end else if (w_can_issue) begin
                        ram_ren     <= 1'b1;
                        ram_addr    <= r_next_addr;
                        r_next_addr <= r_next_addr + ADDR_W'(1);
                    end else begin
                        ram_ren <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (w_accept && out_last_frame) begin
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Pixel capture: threshold, shift in and hold a blocked group aside
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dv         <= 1'b0;
            r_shift      <= '0;
            r_bcnt       <= '0;
            r_pend_valid <= 1'b0;
            r_pend_byte  <= '0;
        end else begin
            r_dv <= ram_ren;
            if (r_dv) begin
                r_shift <= w_byte[6:0];
                r_bcnt  <= r_bcnt + 3'd1;
            end
            if (w_grp_to_pend) begin
                r_pend_valid <= 1'b1;
                r_pend_byte  <= w_byte;
            end else if (w_ld_pend) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    // Output register with markers; load and accept may coincide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_last_row   <= 1'b0;
            out_last_frame <= 1'b0;
            r_col          <= '0;
            r_row          <= '0;
`ifdef PACK_ROW_CHECKSUM_EN
            r_ck_pend      <= 1'b0;
            r_xor          <= '0;
`endif
        end else if (w_start) begin
            r_col <= '0;
            r_row <= '0;
`ifdef PACK_ROW_CHECKSUM_EN
            r_ck_pend <= 1'b0;
            r_xor     <= '0;
`endif
        end else begin
            if (w_ld_data) begin
                out_valid <= 1'b1;
                out_data  <= w_data_byte;
                r_col     <= w_row_end ? '0 : r_col + c_COL_W'(1);
`ifdef PACK_ROW_CHECKSUM_EN
                out_last_row   <= 1'b0;
                out_last_frame <= 1'b0;
                r_xor          <= r_xor ^ w_data_byte;
                if (w_row_end) begin
                    r_ck_pend <= 1'b1;
                end
`else
                out_last_row   <= w_row_end;
                out_last_frame <= w_row_end && (r_row == c_LAST_ROW);
                if (w_row_end) begin
                    r_row <= r_row + c_ROW_W'(1);
                end
`endif
            end
`ifdef PACK_ROW_CHECKSUM_EN
            else if (w_ld_ck) begin
                out_valid      <= 1'b1;
                out_data       <= r_xor;
                out_last_row   <= 1'b1;
                out_last_frame <= (r_row == c_LAST_ROW);
                r_row          <= r_row + c_ROW_W'(1);
                r_xor          <= '0;
                r_ck_pend      <= 1'b0;
            end
`endif
            else if (w_accept) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_halftone_bitpacker.sv
`default_nettype none
// ============================================================================
// Module      : tb_halftone_bitpacker
// Description : Scoreboard bench for halftone_bitpacker on a reduced frame.
//               Expected bytes are computed from the image contents and
//               queued before each frame; a monitor pops on every accept.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_halftone_bitpacker;

    localparam int W    = 64;
    localparam int H    = 16;
    localparam int AW   = 10;
    localparam int TH   = 128;
    localparam int G    = W / 8;
    localparam int NPIX = W * H;
`ifdef PACK_ROW_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          ram_ren;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_odata;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [7:0]    out_data;
    logic          out_last_row;
    logic          out_last_frame;
    logic          busy;
    logic          done;

    logic [7:0] mem [NPIX];
    logic [9:0] sbq [$];

    int  n_vec = 0;
    int  n_err = 0;
    int  cyc = 0;
    int  first_ren_cyc = -1;
    int  first_valid_cyc = -1;
    int  first_addr = -1;
    int  max_addr = 0;
    int  done_cnt = 0;
    int  acc_cnt = 0;
    int  last_acc = -1;
    bit  ready_rnd = 1'b0;
    bit  tp_en = 1'b0;
    bit  prev_stall = 1'b0;
    logic [9:0] prev_bus;
    logic [9:0] act_e;
    logic [9:0] exp_e;

    halftone_bitpacker #(
        .IMG_W (W),
        .IMG_H (H),
        .ADDR_W(AW),
        .THRESH(TH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .ram_ren       (ram_ren),
        .ram_addr      (ram_addr),
        .ram_odata     (ram_odata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_last_row  (out_last_row),
        .out_last_frame(out_last_frame),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    // Synchronous-read image RAM: data one cycle after the read request
    always @(posedge clk) begin
        if (ram_ren) ram_odata <= mem[ram_addr];
    end

    // Consumer ready, changed just after each active edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = ready_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endfunction

    // Monitor: scoreboard pops, handshake hold, stall and timing observations
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (ram_ren) begin
                if (first_ren_cyc < 0) begin
                    first_ren_cyc = cyc;
                    first_addr    = int'(ram_addr);
                end
                if (int'(ram_addr) > max_addr) max_addr = int'(ram_addr);
            end
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (done) done_cnt++;
            if (prev_stall) begin
                check("hold", {out_valid, out_last_frame, out_last_row, out_data}, {1'b1, prev_bus});
                check("stall_ren", ram_ren, 1'b0);
            end
            act_e = {out_last_frame, out_last_row, out_data};
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL extra_byte: got %0h, expected no byte", act_e);
                end else begin
                    exp_e = sbq.pop_front();
                    check($sformatf("byte%0d", acc_cnt), act_e, exp_e);
                end
                if (tp_en && last_acc >= 0) check("interval", cyc - last_acc, 8);
                last_acc = cyc;
                acc_cnt++;
            end
            prev_stall = out_valid && !out_ready;
            prev_bus   = act_e;
        end
    end

    task automatic fill(input int pat);
        for (int a = 0; a < NPIX; a++) begin
            case (pat)
                0:       mem[a] = 8'hFF;
                1:       mem[a] = ((a % W) % 2 == 0) ? 8'hFF : 8'h00;
                2:       mem[a] = ((a % W) == 0) ? 8'hFF : 8'h00;
                3:       mem[a] = ((a % W) % 2 == 0) ? 8'd127 : 8'd128;
                default: mem[a] = 8'($urandom_range(0, 255));
            endcase
        end
    endtask

    // Reference: pack each row's thresholded pixels, MSB first
    task automatic build_expected();
        for (int r = 0; r < H; r++) begin
            logic [7:0] cks;
            cks = 8'h00;
            for (int g = 0; g < G; g++) begin
                logic [7:0] b;
                b = 8'h00;
                for (int k = 0; k < 8; k++) begin
                    if (int'(mem[r*W + g*8 + k]) >= TH) b[7-k] = 1'b1;
                end
                cks ^= b;
                if (CK) sbq.push_back({2'b00, b});
                else    sbq.push_back({(r == H-1 && g == G-1), (g == G-1), b});
            end
            if (CK) sbq.push_back({(r == H-1), 1'b1, cks});
        end
    endtask

    task automatic arm(input bit rnd, input bit tp);
        ready_rnd       = rnd;
        tp_en           = tp;
        first_ren_cyc   = -1;
        first_valid_cyc = -1;
        first_addr      = -1;
        max_addr        = 0;
        done_cnt        = 0;
        acc_cnt         = 0;
        last_acc        = -1;
    endtask

    task automatic check_reset(input string nm);
        check(nm, {ram_ren, ram_addr, out_valid, out_data, out_last_row, out_last_frame, busy, done}, '0);
    endtask

    task automatic run_frame(input bit rnd, input bit tp, input int mid_start, input string nm);
        int t;
        build_expected();
        arm(rnd, tp);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        t = 0;
        while (!done && t < 20000) begin
            @(negedge clk);
            t++;
            start = (t == mid_start);
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got no done after %0d cycles, expected done", nm, t);
            start = 1'b0;
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            sbq.delete();
            return;
        end
        start = 1'b1;                 // lands while in DONE; must be ignored
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        check({nm, "_idle"}, {busy, ram_ren, out_valid}, 3'b000);
        check({nm, "_done_cnt"}, done_cnt, 1);
        check({nm, "_left"}, sbq.size(), 0);
        check({nm, "_latency"}, first_valid_cyc - first_ren_cyc, 9);
        check({nm, "_first_addr"}, first_addr, 0);
        check({nm, "_max_addr"}, max_addr, NPIX - 1);
    endtask

    task automatic reset_test(input int at_byte);
        int t;
        build_expected();
        arm(1'b0, 1'b0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        t = 0;
        while (acc_cnt < at_byte && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check("reset_reach", acc_cnt >= at_byte, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset("reset_mid");
        sbq.delete();
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check_reset("reset_release");
        run_frame(1'b0, !CK, 0, "after_reset");
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset_init");
        rst_n = 1'b1;
        @(negedge clk);

        fill(0); run_frame(1'b0, !CK, 0, "all_ff");
        fill(1); run_frame(1'b0, !CK, 0, "even_cols");
        fill(2); run_frame(1'b0, !CK, 0, "col0");
        fill(3); run_frame(1'b0, !CK, 0, "thresh");
        fill(4); run_frame(1'b0, !CK, 0, "rand_ready1");
        run_frame(1'b1, 1'b0, 300, "rand_ready_rnd");
        fill(4); run_frame(1'b1, 1'b0, 0, "rand2_ready_rnd");
        fill(4); reset_test(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
